// File: rtl/frame_serializer.sv
// Drains the ping-pong frame RAM as a continuous MSB-first serial stream with a bit clock,
// substituting frame-counter service words in the addr[1:0]==0 slots and toggling banks per frame.
module frame_serializer #(
    parameter int unsigned BIT_DIV = 8,
    parameter int unsigned WORD_W  = 12,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              buf_switch,
    output logic              ser_out,
    output logic              ser_clk,
    output logic              word_strb,
    output logic              frame_strb
);
    localparam int unsigned DIV_W  = $clog2(BIT_DIV);
    localparam int unsigned BIT_W  = $clog2(WORD_W);
    localparam int unsigned WAIT_W = $clog2(RD_LAT + 2);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BIT_DIV / 2);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_FULL = WAIT_W'(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        STREAM
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [BIT_W-1:0]   bitc;
    logic [WAIT_W-1:0]  fetch_wait;
    logic [WORD_W-1:0]  hold;
    logic [WORD_W-1:0]  shift;
    logic [9:0]         frame_cnt;
    logic               wrap_pending;
    logic               stop_check;
    logic [11:0]        svc_full;
    logic [WORD_W-1:0]  svc_word;

    assign svc_full = {2'b10, frame_cnt};
    assign svc_word = WORD_W'(svc_full);
    assign ser_out  = shift[WORD_W-1];
    assign rd_bank  = ~buf_switch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_addr      <= '0;
            buf_switch   <= 1'b0;
            shift        <= '0;
            hold         <= '0;
            ser_clk      <= 1'b0;
            word_strb    <= 1'b0;
            frame_strb   <= 1'b0;
            div          <= '0;
            bitc         <= '0;
            fetch_wait   <= '0;
            frame_cnt    <= '0;
            wrap_pending <= 1'b0;
            stop_check   <= 1'b0;
        end else begin
            word_strb  <= 1'b0;
            frame_strb <= 1'b0;

            // RAM word arrives RD_LAT+1 cycles after its address was issued
            if (fetch_wait != '0) begin
                fetch_wait <= fetch_wait - WAIT_ONE;
                if (fetch_wait == WAIT_ONE) begin
                    hold <= (rd_addr[1:0] == 2'b00) ? svc_word : rd_data;
                end
            end

            // Address 0 is fetched one cycle after the toggle so the read hits the new bank
            if (wrap_pending) begin
                wrap_pending <= 1'b0;
                rd_addr      <= '0;
                fetch_wait   <= WAIT_FULL;
            end

            case (state)
                IDLE: begin
                    shift   <= '0;
                    ser_clk <= 1'b0;
                    if (enable) begin
                        rd_addr    <= '0;
                        fetch_wait <= WAIT_FULL;
                        state      <= PREFETCH;
                    end
                end
                PREFETCH: begin
                    if (fetch_wait == WAIT_ONE) begin
                        state <= STREAM;
                        div   <= DIV_LAST;
                        bitc  <= '0;
                    end
                end
                STREAM: begin
                    if (div != DIV_LAST) begin
                        div     <= div + DIV_ONE;
                        ser_clk <= (div + DIV_ONE) < DIV_HALF;
                    end else begin
                        div <= '0;
                        if (bitc != '0) begin
                            bitc    <= bitc - BIT_ONE;
                            shift   <= {shift[WORD_W-2:0], 1'b0};
                            ser_clk <= 1'b1;
                        end else if (stop_check && !enable) begin
                            // enable is only honoured once the whole frame has gone out
                            stop_check <= 1'b0;
                            state      <= IDLE;
                            shift      <= '0;
                            ser_clk    <= 1'b0;
                        end else begin
                            stop_check <= 1'b0;
                            bitc       <= BIT_LAST;
                            shift      <= hold;
                            ser_clk    <= 1'b1;
                            word_strb  <= 1'b1;
                            frame_strb <= (rd_addr == '0);
                            if (&rd_addr) begin
                                buf_switch   <= ~buf_switch;
                                frame_cnt    <= frame_cnt + 10'd1;
                                wrap_pending <= 1'b1;
                                stop_check   <= 1'b1;
                            end else begin
                                rd_addr    <= rd_addr + ADDR_ONE;
                                fetch_wait <= WAIT_FULL;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Downstream neighbour of the word filler. Drains the 1024 x 12 ping-pong frame RAM that the filler writes and emits it as a continuous MSB-first serial telemetry stream with a bit clock.
- Toggles buf_switch at every frame end. This swaps the RAM banks and releases the filler, which stalls at address 1023 until it sees the toggle.
- Address slots with addr[1:0]==0 are never written by the filler. This block replaces them with a service word that carries a frame counter.

Parameters:
- BIT_DIV, 8, clk cycles per serial bit; even, >=4.
- WORD_W, 12, bits per RAM word.
- ADDR_W, 10, RAM address width; frame length = 2^ADDR_W words.
- RD_LAT, 2, RAM read latency in clk cycles from rd_addr to valid rd_data.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  level; start/continue streaming.
- rd_data  in  WORD_W  RAM read data from bank rd_bank.
- rd_addr  out  ADDR_W  RAM read address.
- rd_bank  out  1  bank being read; always equal to ~buf_switch.
- buf_switch  out  1  bank-select toggle to the filler; write bank = buf_switch.
- ser_out  out  1  serial data, MSB first.
- ser_clk  out  1  bit clock; high for the first BIT_DIV/2 cycles of each bit.
- word_strb  out  1  1-cycle pulse on the first cycle of each word's MSB.
- frame_strb  out  1  1-cycle pulse on the first cycle of word 0.

Behaviour:
- Reset values: all outputs 0, rd_bank=1, state IDLE, frame counter 0.
- Clock and reset: clk; reset asynchronous, active-low. Reset mid-frame aborts immediately; no partial buf_switch toggle.
- States: IDLE, PREFETCH, STREAM.
- IDLE: outputs held. When enable is sampled 1: rd_addr<=0, go to PREFETCH.
- PREFETCH: wait RD_LAT+1 cycles, latch the word into the holding register, go to STREAM.
- STREAM timing: bit period = BIT_DIV cycles via div counter 0..BIT_DIV-1; bit counter WORD_W-1 down to 0.
- STREAM word load: at div=0 of bit WORD_W-1, the holding register goes to the shift register. word_strb=1 and ser_out=MSB in that same cycle, so ser_out has 1 cycle latency from the load decision.
- Prefetch during a word: in the same cycle as the load, rd_addr increments (wraps 1023->0). The next word is latched RD_LAT+1 cycles later, into the holding register.
- Service slot: a word whose address has addr[1:0]==0 is replaced in the holding register by {2'b10, frame_cnt[9:0]} for WORD_W=12. For other widths: {2'b10, frame_cnt} truncated or zero-padded to WORD_W. rd_data is ignored for those slots.
- Frame end: when the word at address 2^ADDR_W-1 is loaded into the shift register:
  - buf_switch toggles (rd_bank follows the same cycle);
  - frame_cnt increments, wrapping modulo 2^10;
  - the prefetch of address 0 is issued 1 cycle after the toggle, so it reads the new bank.
- Next frame: the word at address 0 of the new frame asserts frame_strb together with word_strb.
- Continuity: no idle bit between words or frames. Total period = 2^ADDR_W x WORD_W x BIT_DIV cycles.
- enable deasserted mid-frame: the current frame finishes, including the buf_switch toggle, then the block enters IDLE. In IDLE, ser_out=0 and ser_clk=0. Re-enable restarts at address 0 of the current rd_bank.
- enable toggling within a single bit period: no effect until frame end.
- Constraint: BIT_DIV*WORD_W > RD_LAT+2, guaranteed by the legal parameter range. No underrun is possible; the RAM is never empty from this block's view.

Test Plan:
- Reset, then enable=1; RAM bank 1 addr n holds n[11:0] -> first word_strb and frame_strb coincide. ser_out serialises 0x800, the service word with frame_cnt=0. Next word is 0x001 MSB first, 96 clk after the first strobe.
- ser_clk check, BIT_DIV=8 -> ser_clk is 4 high / 4 low. ser_out changes only at ser_clk rising edges. 12 bits per word_strb interval.
- Full frame with BIT_DIV=4 -> buf_switch toggles 1023x48 cycles after the first word_strb. Word at addr 4 of the next frame reads from bank 0. Next service word = 0x801.
- Assert reset mid-word at bit 5 -> all outputs 0 asynchronously. buf_switch=0. On restart the stream begins at address 0 with service word 0x800.
- Drop enable at addr 500 -> streaming continues to addr 1023, buf_switch toggles once, then ser_out=0 and ser_clk=0 hold.
- 1024 frames back-to-back -> frame_cnt wraps: service word 0xBFF followed by 0x800. No gap bits at any frame boundary.
